// File: rtl/tc_rom_access_arbiter.sv
// Round-robin arbiter sharing one combinational 64-bit ROM read port between
// an instruction-fetch requester (A) and a data-load requester (B).
module tc_rom_access_arbiter #(
    parameter int    UUID  = 0,
    parameter string NAME  = "",
    parameter int    DEPTH = 302
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic [63:0] addr_a,
    input  logic [1:0]  size_a,
    output logic        ack_a,
    output logic [63:0] data_a,
    output logic        err_a,
    input  logic        req_b,
    input  logic [63:0] addr_b,
    input  logic [1:0]  size_b,
    output logic        ack_b,
    output logic [63:0] data_b,
    output logic        err_b,
    output logic        rom_en,
    output logic [63:0] rom_address,
    input  logic [63:0] rom_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [63:0] LEN_QUERY_ADDR = 64'hFFFF_FFFF_FFFF_FFFF;

    // Instance identifiers carry no logic; referenced here only so they are used.
    logic unused_params;
    assign unused_params = (UUID != 0) || (NAME != "");

    function automatic logic [63:0] size_mask(input logic [1:0] size);
        logic [63:0] m;
        case (size)
            2'd0:    m = 64'h0000_0000_0000_00FF;
            2'd1:    m = 64'h0000_0000_0000_FFFF;
            2'd2:    m = 64'h0000_0000_FFFF_FFFF;
            default: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

    // addr > DEPTH - n rewritten as addr + n > DEPTH in 65 bits so nothing wraps.
    function automatic logic out_of_range(input logic [63:0] addr, input logic [1:0] size);
        logic [64:0] end_addr;
        end_addr = {1'b0, addr} + (65'd1 << size);
        return end_addr > 65'(DEPTH);
    endfunction

    state_t      state_q, state_d;
    logic        last_q, last_d;     // 0 = A served last, 1 = B served last
    logic        id_q, id_d;
    logic [63:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        rom_en_q, rom_en_d;
    logic [63:0] rom_address_q, rom_address_d;
    logic        ack_a_q, ack_a_d, ack_b_q, ack_b_d;
    logic        err_a_q, err_a_d, err_b_q, err_b_d;
    logic [63:0] data_a_q, data_a_d, data_b_q, data_b_d;
    logic        busy_q, busy_d;

    logic        grant_b;
    logic [63:0] rd_data;
    logic        rd_err;

    always_comb begin
        grant_b = req_b & (~req_a | ~last_q);
        if (addr_q == LEN_QUERY_ADDR) begin
            rd_data = rom_out;
            rd_err  = 1'b0;
        end else if (out_of_range(addr_q, size_q)) begin
            rd_data = 64'd0;
            rd_err  = 1'b1;
        end else begin
            rd_data = rom_out & size_mask(size_q);
            rd_err  = 1'b0;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        id_d          = id_q;
        addr_d        = addr_q;
        size_d        = size_q;
        rom_en_d      = rom_en_q;
        rom_address_d = rom_address_q;
        ack_a_d       = 1'b0;
        ack_b_d       = 1'b0;
        err_a_d       = 1'b0;
        err_b_d       = 1'b0;
        data_a_d      = 64'd0;
        data_b_d      = 64'd0;

        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    id_d          = grant_b;
                    addr_d        = grant_b ? addr_b : addr_a;
                    size_d        = grant_b ? size_b : size_a;
                    rom_en_d      = 1'b1;
                    rom_address_d = grant_b ? addr_b : addr_a;
                    state_d       = READ;
                end
            end
            READ: begin
                rom_en_d      = 1'b0;
                rom_address_d = 64'd0;
                if (id_q) begin
                    ack_b_d  = 1'b1;
                    data_b_d = rd_data;
                    err_b_d  = rd_err;
                end else begin
                    ack_a_d  = 1'b1;
                    data_a_d = rd_data;
                    err_a_d  = rd_err;
                end
                state_d = DONE;
            end
            DONE: begin
                last_d  = id_q;
                state_d = IDLE;
            end
            default: begin
                rom_en_d      = 1'b0;
                rom_address_d = 64'd0;
                state_d       = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_q        <= 1'b1;
            id_q          <= 1'b0;
            addr_q        <= 64'd0;
            size_q        <= 2'd0;
            rom_en_q      <= 1'b0;
            rom_address_q <= 64'd0;
            ack_a_q       <= 1'b0;
            ack_b_q       <= 1'b0;
            err_a_q       <= 1'b0;
            err_b_q       <= 1'b0;
            data_a_q      <= 64'd0;
            data_b_q      <= 64'd0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            id_q          <= id_d;
            addr_q        <= addr_d;
            size_q        <= size_d;
            rom_en_q      <= rom_en_d;
            rom_address_q <= rom_address_d;
            ack_a_q       <= ack_a_d;
            ack_b_q       <= ack_b_d;
            err_a_q       <= err_a_d;
            err_b_q       <= err_b_d;
            data_a_q      <= data_a_d;
            data_b_q      <= data_b_d;
            busy_q        <= busy_d;
        end
    end

    assign ack_a       = ack_a_q;
    assign ack_b       = ack_b_q;
    assign data_a      = data_a_q;
    assign data_b      = data_b_q;
    assign err_a       = err_a_q;
    assign err_b       = err_b_q;
    assign rom_en      = rom_en_q;
    assign rom_address = rom_address_q;
    assign busy        = busy_q;

endmodule
